memory_responder: RTL and testbench
===================================

# memory_responder

Memory-side responder for the CPU datapath's memory port: it receives the word address driven from MAR and the write data driven from MDR, and returns read data on the bus that MDR loads via MMD. It implements a request/acknowledge handshake with a programmable wait-state count, backed by an internal synchronous word-addressed RAM. Out-of-range accesses are flagged, and an optional write-protected low region is available. The sequencer's memory-access states stall on `MEM_BUSY` and advance on `MEM_ACK`.

## Interface
- `ADDR_W`, 10: RAM word-address width; depth is 2^ADDR_W words of 16 bits.
- `WAIT_CYC`, 2: wait states inserted before the array access; legal range 0–15.
- `PROT_LIMIT`, 16'h0040: writes to addresses below this value are protected. Used only when `MEM_PROTECT_EN` is defined.
- `CLK`  in  1: system clock; all state changes on the rising edge.
- `CLR`  in  1: reset, synchronous, active-low.
- `MAR_in`  in  16: word address from MAR.
- `M_bus_wr`  in  16: write data from MDR (MDM path).
- `RD_REQ`  in  1: read request, level. Held high until `MEM_ACK`.
- `WR_REQ`  in  1: write request, level. Held high until `MEM_ACK`.
- `M_bus_rd`  out  16: read data to MDR (MMD path). Registered.
- `MEM_ACK`  out  1: one-cycle completion pulse. Registered.
- `MEM_BUSY`  out  1: high whenever the FSM is not in IDLE.
- `MEM_ERR`  out  1: error status of the completing transaction. Valid only while `MEM_ACK` is high.

## Operation
- FSM states and transitions:
  - IDLE: on a rising edge with `RD_REQ` or `WR_REQ` high, latch `MAR_in`, `M_bus_wr` and the request kind. Go to WAIT with `cnt=WAIT_CYC`, or go directly to ACCESS when `WAIT_CYC=0`.
  - WAIT: `cnt` decrements each cycle. When `cnt==1`, go to ACCESS.
  - ACCESS: a write commits the latched data to the array. A read registers the array word into `M_bus_rd`. Then go to DONE.
  - DONE: `MEM_ACK=1`. Next state is IDLE unconditionally.
- Requests are sampled only in IDLE. `MAR_in`, `M_bus_wr` and the request lines are ignored in every other state. The latched values govern the whole transaction.
- Out-of-range: when `MAR_in[15:ADDR_W] != 0`:
  - a read returns 16'h0000;
  - a write is dropped;
  - `MEM_ERR=1` with the ACK.
- `RD_REQ` and `WR_REQ` both high at acceptance: no array access, `M_bus_rd` unchanged, `MEM_ERR=1`. The normal latency still applies.
- `M_bus_rd` holds its value until the next successful or out-of-range read completes. Writes never change it.
- Reset: `CLR` low at an edge forces IDLE, `cnt=0`, `M_bus_rd=0`, `MEM_ACK=0`, `MEM_BUSY=0`, `MEM_ERR=0`.
  - A write not yet in ACCESS is discarded.
  - RAM contents are not cleared.

## Timing
- Request seen at edge E0 (IDLE): `MEM_BUSY` is high from E0. ACCESS occupies the cycle after E0+WAIT_CYC. `MEM_ACK` and valid `M_bus_rd` are high for exactly the cycle following edge E0+WAIT_CYC+1.
- Total latency from the sampling edge to the ACK cycle is WAIT_CYC+2 cycles (2 when `WAIT_CYC=0`).
- The requester drops its request in the cycle after ACK. The FSM is back in IDLE then and sees it low, so there is no duplicate access. A request still high in that IDLE cycle is accepted as a new transaction.
- Back-to-back throughput is one transaction per WAIT_CYC+3 cycles.
- A write is visible to a read accepted on any later IDLE edge.

## Configuration
- `MEM_PROTECT_EN` defined: a write with latched address < `PROT_LIMIT` (and in range) is dropped, and `MEM_ERR=1` with the ACK. Reads of that region are unaffected.
- `MEM_PROTECT_EN` undefined: `PROT_LIMIT` is unused, and all in-range writes commit.

## Structure
- Shared package `mem_pkg` holds:
  - the FSM state encoding (IDLE=0, WAIT=1, ACCESS=2, DONE=3);
  - the default `ADDR_W`, `WAIT_CYC` and `PROT_LIMIT` constants;
  - the error-cause constants.
- One sub-module, `mem_array`: single-port RAM, 16-bit words, synchronous write, registered synchronous read, no reset on contents. The responder owns the FSM, the wait counter and the range/protect checks.

## Test plan
- Reset, `WAIT_CYC=2`: write 16'hBEEF to address 16'h0100 → ACK exactly 4 cycles after the sampling edge, `MEM_ERR=0`. Then read 16'h0100 → `M_bus_rd=16'hBEEF` in the ACK cycle, `MEM_ERR=0`.
- `WAIT_CYC=0`, with `RD_REQ` held one extra cycle past ACK → ACK 2 cycles after sampling, and exactly one further read is issued. `MEM_BUSY` pattern is 1,1,0,1,1.
- Read address 16'h8000 with `ADDR_W=10` → `M_bus_rd=16'h0000`, `MEM_ERR=1`. A write to 16'h8000 leaves word 0 unchanged.
- `RD_REQ` and `WR_REQ` high together → `MEM_ERR=1`, `M_bus_rd` keeps its prior value, RAM unchanged.
- Write 16'h1234 to 16'h0010 with `CLR` pulsed low while in WAIT → all outputs 0 next cycle, FSM in IDLE. A later read of 16'h0010 returns the old contents.
- With `MEM_PROTECT_EN` defined, write 16'hFFFF to 16'h003F → `MEM_ERR=1`, word unchanged. A write to 16'h0040 → `MEM_ERR=0`, word committed.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and defaults for the memory responder: FSM encoding, default
// geometry/timing and the error-cause codes latched with each transaction.
package mem_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_ACCESS = 2'd2,
        S_DONE   = 2'd3
    } mem_state_e;

    typedef enum logic [1:0] {
        ERR_NONE  = 2'd0,
        ERR_RANGE = 2'd1,
        ERR_BOTH  = 2'd2,
        ERR_PROT  = 2'd3
    } mem_err_e;

    localparam int          ADDR_W_DEF     = 10;
    localparam int          WAIT_CYC_DEF   = 2;
    localparam logic [15:0] PROT_LIMIT_DEF = 16'h0040;

endpackage

// File: rtl/memory_responder_if.sv
// Memory-port bundle between the CPU datapath (master) and the responder (slave).
interface memory_responder_if;
    logic [15:0] MAR_in;
    logic [15:0] M_bus_wr;
    logic        RD_REQ;
    logic        WR_REQ;
    logic [15:0] M_bus_rd;
    logic        MEM_ACK;
    logic        MEM_BUSY;
    logic        MEM_ERR;

    modport slave (
        input  MAR_in, M_bus_wr, RD_REQ, WR_REQ,
        output M_bus_rd, MEM_ACK, MEM_BUSY, MEM_ERR
    );

    modport master (
        output MAR_in, M_bus_wr, RD_REQ, WR_REQ,
        input  M_bus_rd, MEM_ACK, MEM_BUSY, MEM_ERR
    );
endinterface

// File: rtl/mem_array.sv
// Single-port 16-bit word RAM: synchronous write, registered synchronous read.
// Contents and read register are deliberately not reset.
module mem_array #(
    parameter int ADDR_W = 10
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [15:0]       wdata_i,
    output logic [15:0]       rdata_o
);
    logic [15:0] mem_q [2**ADDR_W];
    logic [15:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[addr_i] <= wdata_i;
        if (re_i) rdata_q <= mem_q[addr_i];
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/memory_responder.sv
// Request/ack memory responder with programmable wait states over mem_array.
// Define MEM_PROTECT_EN to drop (and flag) writes below PROT_LIMIT.
module memory_responder
    import mem_pkg::*;
#(
    parameter int          ADDR_W     = ADDR_W_DEF,
    parameter int          WAIT_CYC   = WAIT_CYC_DEF,
    parameter logic [15:0] PROT_LIMIT = PROT_LIMIT_DEF
) (
    input  logic             CLK,
    input  logic             CLR,
    memory_responder_if.slave bus
);
    mem_state_e        state_q;
    mem_err_e          cause_q, cause_d;
    logic [3:0]        cnt_q;
    logic [ADDR_W-1:0] addr_q, arr_addr;
    logic [15:0]       wdata_q, rd_q, arr_rdata;
    logic              is_rd_q, ack_q, busy_q, err_q;
    logic              req, enter_access, arr_we;

    assign req = bus.RD_REQ | bus.WR_REQ;

    always_comb begin
        cause_d = ERR_NONE;
        if (bus.RD_REQ && bus.WR_REQ)        cause_d = ERR_BOTH;
        else if (|(bus.MAR_in >> ADDR_W))    cause_d = ERR_RANGE;
`ifdef MEM_PROTECT_EN
        else if (bus.WR_REQ && bus.MAR_in < PROT_LIMIT) cause_d = ERR_PROT;
`endif
    end

`ifndef MEM_PROTECT_EN
    logic unused_prot;
    assign unused_prot = ^PROT_LIMIT;
`endif

    // The array read is launched on the edge entering ACCESS so the word is
    // already registered when ACCESS hands it to M_bus_rd.
    assign enter_access = (state_q == S_IDLE && req && WAIT_CYC == 0) ||
                          (state_q == S_WAIT && cnt_q == 4'd1);
    assign arr_addr = (state_q == S_IDLE) ? bus.MAR_in[ADDR_W-1:0] : addr_q;
    assign arr_we   = (state_q == S_ACCESS) && !is_rd_q && (cause_q == ERR_NONE);

    mem_array #(.ADDR_W(ADDR_W)) u_array (
        .clk_i   (CLK),
        .we_i    (arr_we),
        .re_i    (enter_access),
        .addr_i  (arr_addr),
        .wdata_i (wdata_q),
        .rdata_o (arr_rdata)
    );

    always_ff @(posedge CLK) begin
        if (!CLR) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rd_q    <= '0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            case (state_q)
                S_IDLE: if (req) begin
                    addr_q  <= bus.MAR_in[ADDR_W-1:0];
                    wdata_q <= bus.M_bus_wr;
                    is_rd_q <= bus.RD_REQ;
                    cause_q <= cause_d;
                    busy_q  <= 1'b1;
                    if (WAIT_CYC == 0) begin
                        state_q <= S_ACCESS;
                    end else begin
                        state_q <= S_WAIT;
                        cnt_q   <= 4'(WAIT_CYC);
                    end
                end
                S_WAIT: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) state_q <= S_ACCESS;
                end
                S_ACCESS: begin
                    // Conflicting requests leave M_bus_rd untouched.
                    if (is_rd_q && cause_q == ERR_NONE)  rd_q <= arr_rdata;
                    if (is_rd_q && cause_q == ERR_RANGE) rd_q <= '0;
                    ack_q   <= 1'b1;
                    err_q   <= (cause_q != ERR_NONE);
                    state_q <= S_DONE;
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.M_bus_rd = rd_q;
    assign bus.MEM_ACK  = ack_q;
    assign bus.MEM_BUSY = busy_q;
    assign bus.MEM_ERR  = err_q;
endmodule

// File: tb/tb_memory_responder.sv
// Directed bench: a WAIT_CYC=2 responder driven from a vector table plus hand
// sequences for zero-wait back-to-back reads and reset during WAIT.
module tb_memory_responder;
    logic CLK = 1'b0;
    logic CLR = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 CLK = ~CLK;

    memory_responder_if b2 ();
    memory_responder_if b0 ();

    memory_responder #(.ADDR_W(10), .WAIT_CYC(2), .PROT_LIMIT(16'h0040)) dut2 (
        .CLK(CLK), .CLR(CLR), .bus(b2)
    );
    memory_responder #(.ADDR_W(10), .WAIT_CYC(0), .PROT_LIMIT(16'h0040)) dut0 (
        .CLK(CLK), .CLR(CLR), .bus(b0)
    );

    typedef struct {
        logic        rd;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic        chk_rd;
        logic [15:0] exp_rd;
        logic        exp_err;
    } vec_t;

    localparam int NV = 15;
    vec_t tbl [NV];

`ifdef MEM_PROTECT_EN
    localparam bit          PROT   = 1'b1;
    localparam logic [15:0] RST_AD = 16'h0110;
`else
    localparam bit          PROT   = 1'b0;
    localparam logic [15:0] RST_AD = 16'h0010;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One transaction on dut2; request held until ACK, then dropped.
    task automatic xact2(input logic rd, input logic wr, input logic [15:0] addr,
                         input logic [15:0] wdata, output int lat,
                         output logic [15:0] rdv, output logic err);
        @(posedge CLK); #1;
        b2.RD_REQ = rd; b2.WR_REQ = wr; b2.MAR_in = addr; b2.M_bus_wr = wdata;
        @(posedge CLK); #1;
        lat = 1;
        while (!b2.MEM_ACK && lat < 20) begin
            @(posedge CLK); #1;
            lat++;
        end
        rdv = b2.M_bus_rd;
        err = b2.MEM_ERR;
        b2.RD_REQ = 1'b0; b2.WR_REQ = 1'b0;
    endtask

    initial begin
        int          lat;
        logic [15:0] rdv;
        logic        err;
        logic [4:0]  busy_pat;
        int          acks;

        tbl[0]  = '{1'b0, 1'b1, 16'h0100, 16'hBEEF, 1'b1, 16'h0000, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 16'h0100, 16'h0000, 1'b1, 16'hBEEF, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 16'h0000, 16'h5555, 1'b1, 16'hBEEF, PROT};
        tbl[3]  = '{1'b1, 1'b0, 16'h8000, 16'h0000, 1'b1, 16'h0000, 1'b1};
        tbl[4]  = '{1'b0, 1'b1, 16'h8000, 16'hAAAA, 1'b1, 16'h0000, 1'b1};
        tbl[5]  = '{1'b1, 1'b0, 16'h0000, 16'h0000, !PROT, 16'h5555, 1'b0};
        tbl[6]  = '{1'b1, 1'b0, 16'h0100, 16'h0000, 1'b1, 16'hBEEF, 1'b0};
        tbl[7]  = '{1'b1, 1'b1, 16'h0100, 16'h1111, 1'b1, 16'hBEEF, 1'b1};
        tbl[8]  = '{1'b1, 1'b0, 16'h0100, 16'h0000, 1'b1, 16'hBEEF, 1'b0};
        tbl[9]  = '{1'b0, 1'b1, 16'h003F, 16'hFFFF, 1'b1, 16'hBEEF, PROT};
        tbl[10] = '{1'b1, 1'b0, 16'h003F, 16'h0000, !PROT, 16'hFFFF, 1'b0};
        tbl[11] = '{1'b0, 1'b1, 16'h0040, 16'h7777, 1'b0, 16'h0000, 1'b0};
        tbl[12] = '{1'b1, 1'b0, 16'h0040, 16'h0000, 1'b1, 16'h7777, 1'b0};
        tbl[13] = '{1'b0, 1'b1, 16'h03FF, 16'h0A0A, 1'b0, 16'h0000, 1'b0};
        tbl[14] = '{1'b1, 1'b0, 16'h0400, 16'h0000, 1'b1, 16'h0000, 1'b1};

        b2.RD_REQ = 0; b2.WR_REQ = 0; b2.MAR_in = 0; b2.M_bus_wr = 0;
        b0.RD_REQ = 0; b0.WR_REQ = 0; b0.MAR_in = 0; b0.M_bus_wr = 0;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_outs2", {b2.M_bus_rd, b2.MEM_ACK, b2.MEM_BUSY, b2.MEM_ERR}, 32'h0);
        chk("rst_outs0", {b0.M_bus_rd, b0.MEM_ACK, b0.MEM_BUSY, b0.MEM_ERR}, 32'h0);
        CLR = 1'b1;

        for (int i = 0; i < NV; i++) begin
            xact2(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wdata, lat, rdv, err);
            chk($sformatf("v%0d_lat", i), lat, 4);
            chk($sformatf("v%0d_err", i), err, tbl[i].exp_err);
            if (tbl[i].chk_rd) chk($sformatf("v%0d_rd", i), rdv, tbl[i].exp_rd);
        end
        xact2(1'b1, 1'b0, 16'h03FF, 16'h0, lat, rdv, err);
        chk("top_word_rd", rdv, 16'h0A0A);

        // Zero-wait responder: write, then a read held one cycle past ACK.
        @(posedge CLK); #1;
        b0.WR_REQ = 1; b0.MAR_in = 16'h0105; b0.M_bus_wr = 16'h4321;
        @(posedge CLK); #1;
        chk("w0_busy_c1", {b0.MEM_BUSY, b0.MEM_ACK}, 2'b10);
        @(posedge CLK); #1;
        chk("w0_ack_c2", {b0.MEM_ACK, b0.MEM_ERR}, 2'b10);
        b0.WR_REQ = 0;
        @(posedge CLK); #1;
        b0.RD_REQ = 1;
        busy_pat = '0;
        acks = 0;
        for (int c = 1; c <= 7; c++) begin
            @(posedge CLK); #1;
            if (c <= 5) busy_pat = {busy_pat[3:0], b0.MEM_BUSY};
            if (b0.MEM_ACK) acks++;
            if (c == 2 || c == 5) chk($sformatf("r0_rd_c%0d", c), {b0.MEM_ACK, b0.M_bus_rd}, {1'b1, 16'h4321});
            if (c == 4) b0.RD_REQ = 0;
        end
        chk("r0_busy_pat", busy_pat, 5'b11011);
        chk("r0_ack_count", acks, 2);

        // Reset while a write sits in WAIT: write is discarded.
        xact2(1'b0, 1'b1, RST_AD, 16'h0F0F, lat, rdv, err);
        chk("pre_wr_err", err, 1'b0);
        @(posedge CLK); #1;
        b2.WR_REQ = 1; b2.MAR_in = RST_AD; b2.M_bus_wr = 16'h1234;
        @(posedge CLK); #1;
        chk("wait_busy", b2.MEM_BUSY, 1'b1);
        CLR = 1'b0; b2.WR_REQ = 0;
        @(posedge CLK); #1;
        chk("rst_wait_outs", {b2.M_bus_rd, b2.MEM_ACK, b2.MEM_BUSY, b2.MEM_ERR}, 32'h0);
        CLR = 1'b1;
        acks = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge CLK); #1;
            if (b2.MEM_ACK || b2.MEM_BUSY) acks++;
        end
        chk("rst_no_resume", acks, 0);
        xact2(1'b1, 1'b0, RST_AD, 16'h0, lat, rdv, err);
        chk("rst_old_word", {err, rdv}, {1'b0, 16'h0F0F});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
